// File: rtl/mac_pkg.sv
// Shared state encoding and default widths for the pipelined multiply-accumulate block.
package mac_pkg;

  localparam int DEF_N     = 16;
  localparam int DEF_M     = 16;
  localparam int DEF_GUARD = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } mac_state_e;

endpackage

// File: rtl/mac_mul_reg.sv
// Stage 1: registered signed N x M multiply that carries valid/last alongside the product.
module mac_mul_reg
  import mac_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic signed [N-1:0]   a_i,
  input  logic signed [M-1:0]   b_i,
  output logic                  valid_o,
  output logic                  last_o,
  output logic signed [N+M-1:0] prod_o
);

  logic                  valid_q;
  logic                  last_q;
  logic signed [N+M-1:0] prod_q;
  logic signed [N+M-1:0] prod_d;

  // Both operands are widened before multiplying so the full product is kept.
  assign prod_d = (N+M)'(a_i) * (N+M)'(b_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      valid_q <= valid_i;
      last_q  <= valid_i && last_i;
      if (valid_i) begin
        prod_q <= prod_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign prod_o  = prod_q;

endmodule

// File: rtl/mac_acc_pipe.sv
// Two-stage signed dot-product engine: multiply stage, accumulate stage, result hold.
// Define MAC_ACC_SAT_EN to clamp the accumulate on overflow instead of wrapping.
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int ACC_W = N + M + DEF_GUARD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     a,
  input  logic signed [M-1:0]     b,
  input  logic                    in_last,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0]        out_count,
  output logic                    ovf
);

  mac_state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    runOvf_q, runOvf_d;
  logic signed [ACC_W-1:0] accOut_q, accOut_d;
  logic [CNT_W-1:0]        outCount_q, outCount_d;
  logic                    outOvf_q, outOvf_d;
  logic                    outValid_q, outValid_d;

  logic                    s1Valid;
  logic                    s1Last;
  logic signed [N+M-1:0]   s1Prod;
  logic                    accept;
  logic                    abortEff;
  logic signed [ACC_W-1:0] prodExt;
  logic signed [ACC_W-1:0] sumRaw;
  logic signed [ACC_W-1:0] sumNext;
  logic                    sumOvf;
  logic [CNT_W-1:0]        cntInc;

  // Abort is only honoured while a vector can still be open; a pending result is kept.
  assign abortEff = abort && (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign in_ready = !rst && (state_q != HOLD) && !(s1Valid && s1Last);

  mac_mul_reg #(
    .N(N),
    .M(M)
  ) u_stage1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(abortEff),
    .valid_i(accept && !abortEff),
    .last_i (in_last),
    .a_i    (a),
    .b_i    (b),
    .valid_o(s1Valid),
    .last_o (s1Last),
    .prod_o (s1Prod)
  );

  assign prodExt = ACC_W'(s1Prod);
  assign sumRaw  = acc_q + prodExt;
  assign sumOvf  = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) && (sumRaw[ACC_W-1] != acc_q[ACC_W-1]);
  assign cntInc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef MAC_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Overflow direction follows the accumulator sign, since both addends share it.
  always_comb begin
    sumNext = sumRaw;
    if (sumOvf) begin
      sumNext = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  assign sumNext = sumRaw;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    runOvf_d   = runOvf_q;
    accOut_d   = accOut_q;
    outCount_d = outCount_q;
    outOvf_d   = outOvf_q;
    outValid_d = outValid_q;

    if (abortEff) begin
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      runOvf_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s1Valid) begin
            acc_d    = prodExt;
            cnt_d    = CNT_W'(1);
            runOvf_d = 1'b0;
            state_d  = ACC;
            if (s1Last) begin
              accOut_d   = prodExt;
              outCount_d = CNT_W'(1);
              outOvf_d   = 1'b0;
              outValid_d = 1'b1;
              state_d    = HOLD;
            end
          end
        end
        ACC: begin
          if (s1Valid) begin
            acc_d    = sumNext;
            cnt_d    = cntInc;
            runOvf_d = runOvf_q || sumOvf;
            if (s1Last) begin
              accOut_d   = sumNext;
              outCount_d = cntInc;
              outOvf_d   = runOvf_q || sumOvf;
              outValid_d = 1'b1;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            outValid_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      runOvf_q   <= 1'b0;
      accOut_q   <= '0;
      outCount_q <= '0;
      outOvf_q   <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      runOvf_q   <= runOvf_d;
      accOut_q   <= accOut_d;
      outCount_q <= outCount_d;
      outOvf_q   <= outOvf_d;
      outValid_q <= outValid_d;
    end
  end

  assign out_valid = outValid_q;
  assign acc_out   = accOut_q;
  assign out_count = outCount_q;
  assign ovf       = outOvf_q;

endmodule
